// File: rtl/project_types.sv
// project_types: shared stall vectors and multicycle sequencer states for pipe_ctrl.
package project_types;
   typedef logic [5:0] stall_t;
   localparam stall_t STALL_NONE = 6'b000000;
   localparam stall_t STALL_IF   = 6'b000011;
   localparam stall_t STALL_ID   = 6'b000111;
   localparam stall_t STALL_EX   = 6'b001111;
   localparam stall_t STALL_MEM  = 6'b011111;
   localparam int MC_CNT_W = 6;
   typedef enum logic [1:0] {RUN, BUSY, DONE} mc_state_t;
endpackage

// File: rtl/mc_seq.sv
// mc_seq: multicycle EX op sequencer (RUN -> BUSY -> DONE) with its cycle counter.
module mc_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] cycles,
   input  logic       mem_stall,
   output logic       ex_stall,
   output logic       busy,
   output logic       done
);
   import project_types::*;
   mc_state_t state;
   logic [MC_CNT_W-1:0] cnt;
   logic busy_q, done_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            RUN: if (start) begin
               cnt    <= (cycles == '0) ? MC_CNT_W'(1) : cycles;
               state  <= BUSY;
               busy_q <= 1'b1;
            end
            BUSY: begin
               cnt <= cnt - MC_CNT_W'(1);
               if (cnt == MC_CNT_W'(1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            DONE: if (!mem_stall) begin
               state  <= RUN;
               done_q <= 1'b0;
            end
            default: begin
               state  <= RUN;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end
   // Reset is synchronous, so outputs are masked while rst is held.
   assign ex_stall = !rst && ((state == RUN && start) || state == BUSY);
   assign busy     = !rst && busy_q;
   assign done     = !rst && done_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hold vector, delay-slot tracking and optional PC-stall counter.
// Define PIPE_CTRL_PERF_EN to add perf_stall_cnt_o.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_stall_req,
   input  logic        id_load_use,
   input  logic        ex_mc_start,
   input  logic [5:0]  ex_mc_cycles,
   input  logic        mem_stall_req,
   input  logic        id_jump_en,
   output logic [5:0]  stall_o,
   output logic        ex_mc_busy_o,
   output logic        ex_mc_done_o,
   output logic        delay_slot_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt_o
`endif
);
   import project_types::*;
   logic ex_stall;
   mc_seq u_mc_seq (
      .clk       (clk),
      .rst       (rst),
      .start     (ex_mc_start),
      .cycles    (ex_mc_cycles),
      .mem_stall (mem_stall_req),
      .ex_stall  (ex_stall),
      .busy      (ex_mc_busy_o),
      .done      (ex_mc_done_o)
   );
   always_comb
      stall_o = rst           ? STALL_NONE :
                mem_stall_req ? STALL_MEM  :
                ex_stall      ? STALL_EX   :
                id_load_use   ? STALL_ID   :
                if_stall_req  ? STALL_IF   : STALL_NONE;
   // A jump seen while ID is held only counts once ID actually advances.
   always_ff @(posedge clk)
      delay_slot_o <= rst ? 1'b0 : (stall_o[2] ? delay_slot_o : id_jump_en);
`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk)
      if (rst) perf_stall_cnt_o <= '0;
      else if (stall_o[0] && perf_stall_cnt_o != '1) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
`endif
endmodule
